// File: rtl/index_decoder_set_pkg.sv
// Shared definitions for the index decoder set block.
package index_decoder_set_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/index_decoder_set_one_hot_decoder.sv
// Combinational index-to-one-hot decode.
// Out-of-range indices decode to all zeros and drop in_range.
module one_hot_decoder #(
  parameter int IN_WIDTH = 1,
  parameter int LINES    = 1 << IN_WIDTH
) (
  input  logic [IN_WIDTH-1:0] index,
  output logic [LINES-1:0]    onehot,
  output logic                in_range
);

  for (genvar i = 0; i < LINES; i++) begin : g_line
    assign onehot[i] = (32'(index) == i);
  end

  assign in_range = (32'(index) < LINES);

endmodule

// File: rtl/index_decoder_set.sv
// Pending-line set: sets raise lines, clears lower them, with a popcount,
// error pulses, and a RUN/DRAIN gate on incoming sets.
module index_decoder_set
  import index_decoder_set_pkg::*;
#(
  parameter int IN_WIDTH = 1,
  parameter int LINES    = 1 << IN_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] set_index,
  input  logic                set_valid,
  output logic                set_ready,
  input  logic [IN_WIDTH-1:0] clear_index,
  input  logic                clear_valid,
  input  logic                drain,
  output logic [LINES-1:0]    lines,
  output logic                any,
  output logic [IN_WIDTH:0]   count,
  output logic                range_err,
  output logic                dup_set
);

  logic [LINES-1:0] set_oh, clr_oh, set_eff, clr_eff, lines_n;
  logic             set_in_range, clr_in_range, set_acc, inc, dec;
  state_t           state, state_n;

  one_hot_decoder #(.IN_WIDTH(IN_WIDTH), .LINES(LINES)) u_set_dec (
    .index(set_index), .onehot(set_oh), .in_range(set_in_range)
  );

  one_hot_decoder #(.IN_WIDTH(IN_WIDTH), .LINES(LINES)) u_clr_dec (
    .index(clear_index), .onehot(clr_oh), .in_range(clr_in_range)
  );

  // Next mask: clear first, then set, so a same-index collision leaves the line set.
  // Count moves by the net delta so it tracks popcount without an adder tree.
  always_comb begin
    set_acc = set_valid & set_ready;
    set_eff = (set_acc && set_in_range) ? set_oh : '0;
    clr_eff = (clear_valid && clr_in_range) ? clr_oh : '0;
    lines_n = (lines & ~clr_eff) | set_eff;
    inc     = |(set_eff & ~lines);
    dec     = |(clr_eff & lines & ~set_eff);
  end

  // RUN/DRAIN next-state; leave DRAIN only once empty and drain released.
  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (drain) state_n = DRAIN;
      DRAIN:   if ((count == '0) && !drain) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // FSM state and its registered set_ready view.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= RUN;
      set_ready <= 1'b1;
    end else begin
      state     <= state_n;
      set_ready <= (state_n == RUN);
    end
  end

  // Mask, count, summary and one-cycle error pulses.
  // A set colliding with a same-index clear is not a duplicate.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lines     <= '0;
      count     <= '0;
      any       <= 1'b0;
      range_err <= 1'b0;
      dup_set   <= 1'b0;
    end else begin
      lines     <= lines_n;
      count     <= count + (IN_WIDTH+1)'(inc) - (IN_WIDTH+1)'(dec);
      any       <= |lines_n;
      range_err <= (set_acc & ~set_in_range) | (clear_valid & ~clr_in_range);
      dup_set   <= |(set_eff & lines & ~clr_eff);
    end
  end

endmodule

// File: doc/index_decoder_set.md
INDEX_DECODER_SET -- requirements
Module: index_decoder_set

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 1, meaning the width of the set/clear index inputs.
REQ-002 SHALL have parameter LINES, default 1 << IN_WIDTH, meaning the number of output lines; LINES <= 1 << IN_WIDTH.
REQ-003 SHALL have one clock and a synchronous, active-low reset; the ports are as follows.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 set_index  input  IN_WIDTH  line index to raise.
REQ-007 set_valid  input  1  set request; accepted when set_valid & set_ready.
REQ-008 set_ready  output  1  block can accept a set this cycle.
REQ-009 clear_index  input  IN_WIDTH  line index to lower.
REQ-010 clear_valid  input  1  clear request; always accepted.
REQ-011 drain  input  1  request to stop accepting sets until all lines are clear.
REQ-012 lines  output  LINES  registered pending mask, one bit per index.
REQ-013 any  output  1  OR of lines, registered.
REQ-014 count  output  IN_WIDTH+1  registered number of set bits in lines.
REQ-015 range_err  output  1  one-cycle pulse: accepted set or clear index >= LINES.
REQ-016 dup_set  output  1  one-cycle pulse: accepted set hit an already-set line.

Function
REQ-017 An accepted set SHALL raise lines[set_index] on the next clock edge (latency 1); lines SHALL never change combinationally.
REQ-018 A clear SHALL lower lines[clear_index] on the next edge; clearing an already-clear line SHALL be a no-op with no pulse.
REQ-019 A set and clear to the same index in one cycle SHALL leave the line set (set wins); count SHALL be updated accordingly.
REQ-020 A set and clear to different indices in one cycle SHALL both take effect; count SHALL change by the net delta (-1, 0 or +1).
REQ-021 An index >= LINES on an accepted set or clear SHALL leave lines and count unchanged and pulse range_err the next cycle.
REQ-022 A set to an already-set line SHALL leave count unchanged and pulse dup_set the next cycle.
REQ-023 count SHALL always equal popcount(lines) and SHALL saturate neither up nor down, since it is bounded to 0..LINES by construction.
REQ-024 any SHALL equal (count != 0) in every cycle.
REQ-025 The FSM SHALL have two states: RUN and DRAIN.
REQ-026 In RUN, set_ready SHALL be 1.
REQ-027 In RUN, drain=1 SHALL move the FSM to DRAIN on the next edge.
REQ-028 In DRAIN, set_ready SHALL be 0; clears SHALL still be accepted.
REQ-029 In DRAIN, the FSM SHALL return to RUN on the edge after count reaches 0 with drain=0.
REQ-030 If drain stays high in DRAIN with count = 0, the FSM SHALL remain in DRAIN.
REQ-031 set_ready SHALL be a registered output derived from the FSM state.

Reset
REQ-032 With reset_n=0 at a clock edge, the block SHALL apply: lines=0, count=0, any=0, range_err=0, dup_set=0, FSM=RUN, set_ready=1.
REQ-033 Reset SHALL override any concurrent set, clear or drain in that cycle, including reset mid-DRAIN.

Structure
REQ-034 The FSM state enum (RUN, DRAIN) SHALL live in the shared core package; no other package content is needed.
REQ-035 Index-to-one-hot decode with range check SHALL be a combinational sub-module one_hot_decoder (IN_WIDTH, LINES -> onehot, in_range), instantiated once for set and once for clear.

Verification
REQ-036 IN_WIDTH=2, LINES=3: set 0, 2 on consecutive cycles -> lines=3'b001 then 3'b101, count=2, any=1.
REQ-037 LINES=3: set index 3 -> lines unchanged, range_err pulses for exactly 1 cycle; clear index 3 -> range_err pulses again.
REQ-038 lines=3'b010: set 1 and clear 1 in the same cycle -> lines stays 3'b010, count=1, no dup_set; set 1 alone -> dup_set pulses once.
REQ-039 lines=3'b011: drain=1 for 1 cycle -> set_ready=0 and a set of index 2 is ignored; clear 0, then clear 1 -> count reaches 0 and the FSM returns to RUN with set_ready=1 on the following edge.
REQ-040 In DRAIN with lines=3'b111, assert reset_n=0 for 1 cycle -> lines=0, count=0, set_ready=1 after the edge.
REQ-041 A random set/clear/drain sequence of 10k cycles SHALL hold count == popcount(lines) and any == |lines on every cycle.
